// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer and related
// input-conditioning blocks.
// Contents: db_state_t FSM encoding, default stability count and prescaler width.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } db_state_t;

   // 50000 samples is 1 ms at a 50 MHz system clock.
   localparam int DB_STABLE_CYCLES_DEF = 50000;
   localparam int DB_PRESCALE_W_DEF    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clock edges from input sample to o_q. No backpressure.
// Ports: clk, rst_n (async active-low, clears both flops), i_d (async in), o_q (synced out).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw pushbutton/switch level into a clean level plus rise/fall pulses.
// Latency: 2+STABLE_CYCLES edges (2+STABLE_CYCLES*2^PRESCALE_W with prescaler). No backpressure.
// Ports: clk, rst_n (async active-low), signal_in (raw async), signal_out (level),
//        rise_pulse / fall_pulse (one-clock events when signal_out changes).
// Optional: define DEBOUNCE_PRESCALE_EN to advance the stability count only once
//           every 2^PRESCALE_W clocks; bounce abort is still checked every clock.
module button_debouncer #(
   parameter int STABLE_CYCLES = debounce_pkg::DB_STABLE_CYCLES_DEF,
   parameter int PRESCALE_W    = debounce_pkg::DB_PRESCALE_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic signal_in,
   output logic signal_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   import debounce_pkg::*;

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   // Marker block: only elaborates for out-of-range parameters, which makes
   // a bad configuration easy to spot in the elaborated hierarchy.
   if (STABLE_CYCLES < 1 || PRESCALE_W < 1) begin : g_illegal_params
   end

   logic       w_s_sync;
   logic       w_tick;

   db_state_t  r_state;
   db_state_t  w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic       r_signal_out;
   logic       r_rise;
   logic       r_fall;
   logic       w_out_nxt;
   logic       w_rise_nxt;
   logic       w_fall_nxt;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (signal_in),
      .o_q   (w_s_sync)
   );

`ifdef DEBOUNCE_PRESCALE_EN
   logic [PRESCALE_W-1:0] r_pre;
   logic [PRESCALE_W-1:0] w_pre_nxt;

   // The count step happens on the clock where the prescaler wraps back to 0.
   assign w_tick = &r_pre;

   // Prescaler runs only while staying in a WAIT state; any entry into a
   // WAIT state (or leaving one) restarts it from 0.
   always_comb begin
      w_pre_nxt = '0;
      if ((r_state == WAIT_HIGH || r_state == WAIT_LOW) && (w_state_nxt == r_state)) begin
         w_pre_nxt = r_pre + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else begin
         r_pre <= w_pre_nxt;
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LOW;
         r_cnt        <= '0;
         r_signal_out <= 1'b0;
         r_rise       <= 1'b0;
         r_fall       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_signal_out <= w_out_nxt;
         r_rise       <= w_rise_nxt;
         r_fall       <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      w_out_nxt   = 1'b0;

      case (r_state)
         LOW: begin
            if (w_s_sync) begin
               w_state_nxt = WAIT_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            // Abort is checked before the tick so a bounce is caught every clock.
            if (!w_s_sync) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = '0;
            end else if (w_tick) begin
               if (r_cnt == LP_CNT_MAX) begin
                  w_state_nxt = HIGH;
                  w_cnt_nxt   = '0;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         HIGH: begin
            if (!w_s_sync) begin
               w_state_nxt = WAIT_LOW;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (w_s_sync) begin
               w_state_nxt = HIGH;
               w_cnt_nxt   = '0;
            end else if (w_tick) begin
               if (r_cnt == LP_CNT_MAX) begin
                  w_state_nxt = LOW;
                  w_cnt_nxt   = '0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
         end
      endcase

      // Level follows the committed side of the FSM: WAIT states still show
      // the old level until the new one has been held long enough.
      w_out_nxt = (w_state_nxt == HIGH) || (w_state_nxt == WAIT_LOW);
   end

   assign signal_out = r_signal_out;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=4
// (PRESCALE_W=2 when DEBOUNCE_PRESCALE_EN is defined).
// A run-length reference model pushes expected outputs per driven sample.
module tb_button_debouncer;

   localparam int N = 4;
`ifdef DEBOUNCE_PRESCALE_EN
   localparam int PW  = 2;
   localparam int LAT = 2 + N * (1 << PW);
`else
   localparam int PW  = 8;
   localparam int LAT = 2 + N;
`endif
   // Consecutive synchronized samples of the new level needed before a flip.
   localparam int THRESH = LAT - 1;

   typedef struct {
      logic out;
      logic rise;
      logic fall;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic signal_in;
   logic signal_out;
   logic rise_pulse;
   logic fall_pulse;

   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;
   int n_rise = 0;
   int n_fall = 0;
   int last_rise = -1;
   int last_fall = -1;

   // Reference model state: synchronizer copy, debounced level, run length.
   logic m_ff1, m_ff2, m_out;
   int   m_run;

   button_debouncer #(
      .STABLE_CYCLES (N),
      .PRESCALE_W    (PW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .signal_in  (signal_in),
      .signal_out (signal_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      m_ff1 = 1'b0;
      m_ff2 = 1'b0;
      m_out = 1'b0;
      m_run = 0;
      sb_q.delete();
   endtask

   // Drive one sample, predict the outputs after the next edge, then compare.
   task automatic step(input logic v);
      exp_t e;
      exp_t g;
      logic s;
      signal_in = v;
      s     = m_ff2;
      m_ff2 = m_ff1;
      m_ff1 = v;
      e.rise = 1'b0;
      e.fall = 1'b0;
      if (s != m_out) begin
         m_run++;
         if (m_run == THRESH) begin
            m_out  = s;
            m_run  = 0;
            e.rise = s;
            e.fall = ~s;
         end
      end else begin
         m_run = 0;
      end
      e.out = m_out;
      sb_q.push_back(e);

      @(posedge clk);
      #2;
      edge_n++;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         g = sb_q.pop_front();
         check_eq("signal_out", signal_out, g.out);
         check_eq("rise_pulse", rise_pulse, g.rise);
         check_eq("fall_pulse", fall_pulse, g.fall);
         check_eq("rise_and_fall", rise_pulse & fall_pulse, 1'b0);
      end
      if (rise_pulse) begin
         n_rise++;
         last_rise = edge_n;
      end
      if (fall_pulse) begin
         n_fall++;
         last_fall = edge_n;
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   // Assert reset between edges, confirm outputs clear without a clock edge,
   // keep it for a few edges, then release away from the edge.
   task automatic async_reset(input logic in_during);
      signal_in = in_during;
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_out", signal_out, 1'b0);
      check_eq("rst_async_rise", rise_pulse, 1'b0);
      check_eq("rst_async_fall", fall_pulse, 1'b0);
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_hold_out", signal_out, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      int first;
      int r0;
      int f0;

      rst_n = 1'b0;
      signal_in = 1'b0;
      model_reset();
      #1;
      check_eq("reset_out", signal_out, 1'b0);
      check_eq("reset_rise", rise_pulse, 1'b0);
      check_eq("reset_fall", fall_pulse, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Clean step.
      hold(1'b0, 10);
      first = edge_n + 1;
      r0 = n_rise;
      f0 = n_fall;
      hold(1'b1, LAT + 4);
      check_eq("step_rise_edge", last_rise, first + LAT);
      check_eq("step_rise_count", n_rise - r0, 1);
      check_eq("step_no_fall", n_fall - f0, 0);

      // Release from HIGH.
      first = edge_n + 1;
      f0 = n_fall;
      hold(1'b0, LAT + 4);
      check_eq("release_fall_edge", last_fall, first + LAT);
      check_eq("release_fall_count", n_fall - f0, 1);

      // Bounce rejection, then a real press.
      r0 = n_rise;
      step(1'b1); step(1'b0); step(1'b1); step(1'b0);
      hold(1'b0, 6);
      check_eq("bounce_no_rise", n_rise - r0, 0);
      first = edge_n + 1;
      hold(1'b1, LAT + 4);
      check_eq("press_rise_edge", last_rise, first + LAT);
      check_eq("press_rise_count", n_rise - r0, 1);

      // Short low glitch from HIGH is ignored.
      f0 = n_fall;
      hold(1'b0, 3);
      hold(1'b1, 10);
      check_eq("low_glitch_no_fall", n_fall - f0, 0);
      check_eq("low_glitch_level", signal_out, 1'b1);

      // Back to LOW, then a 5-clock high glitch (model decides the outcome).
      hold(1'b0, LAT + 4);
      hold(1'b1, 5);
      hold(1'b0, LAT + 6);

      // Reset while WAIT_LOW with the level still high, release with input high.
      hold(1'b1, LAT + 4);
      hold(1'b0, 5);
      check_eq("pre_reset_high", signal_out, 1'b1);
      async_reset(1'b1);
      first = edge_n + 1;
      r0 = n_rise;
      hold(1'b1, LAT + 4);
      check_eq("rel_high_rise_edge", last_rise, first + LAT);
      check_eq("rel_high_rise_count", n_rise - r0, 1);

      // Reset while WAIT_HIGH with cnt=2.
      hold(1'b0, LAT + 4);
      hold(1'b1, 5);
      async_reset(1'b1);
      first = edge_n + 1;
      r0 = n_rise;
      hold(1'b1, LAT + 4);
      check_eq("midcnt_rise_edge", last_rise, first + LAT);
      check_eq("midcnt_rise_count", n_rise - r0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
